mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//  Owns the single-port unified memory in the multicycle core. Arbitrates between
//  instruction fetch (IF) and load/store (LS) requesters, then drives word address,
//  byte enables and replicated write data. Waits on the memory ack and returns
//  extracted, sign/zero-extended load data. Flags misaligned/illegal accesses and
//  memory timeouts instead of issuing them.
// PARAMETERS
//  LS_PRIORITY     1    1: LS wins simultaneous requests; 0: round-robin on last grant
//  TIMEOUT_CYCLES  255  max cycles in ACCESS waiting for mem_ack (>=1, 8-bit counter)
// PORTS
//  clk          in   1   core clock, all state on rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  if_req       in   1   fetch request, held until if_gnt
//  if_addr      in   32  fetch byte address
//  if_gnt       out  1   1-cycle pulse: IF request accepted
//  if_rvalid    out  1   1-cycle pulse: fetch result (if_rdata, rsp_fault) valid
//  if_rdata     out  32  fetched word
//  ls_req       in   1   load/store request, held until ls_gnt
//  ls_we        in   1   1 = store
//  ls_addr      in   32  byte address
//  ls_funct3    in   3   RV32I width/sign field
//  ls_wdata     in   32  store data (rs2), low bits significant
//  ls_gnt       out  1   1-cycle pulse: LS request accepted
//  ls_rvalid    out  1   1-cycle pulse: LS completion (ls_rdata, rsp_fault) valid
//  ls_rdata     out  32  extended load result; 0 for stores/faults
//  rsp_fault    out  1   qualifies rvalid: misaligned/illegal funct3 (no mem access)
//  timeout_err  out  1   qualifies rvalid: mem_ack not seen within TIMEOUT_CYCLES
//  mem_req      out  1   memory strobe, held high through ACCESS
//  mem_we       out  1   write enable
//  mem_addr     out  32  {addr[31:2],2'b00}
//  mem_be       out  4   byte lane enables
//  mem_wdata    out  32  lane-replicated write data
//  mem_rdata    in   32  read word, valid with mem_ack
//  mem_ack      in   1   access complete
//  busy         out  1   state != IDLE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all outputs 0; last_grant=LS (IF wins first RR tie).
//   A reset during ACCESS drops mem_req immediately; in-flight access is abandoned.
//  FSM IDLE -> {ACCESS|RESP}; ACCESS -> RESP; RESP -> IDLE.
//  IDLE: pick winner (LS_PRIORITY or RR), pulse its gnt, register addr/we/funct3/wdata/owner.
//   Legal request -> ACCESS. Fault request -> RESP with rsp_fault=1 and no mem_req.
//   Loser keeps req high and is served at the next IDLE.
//  ACCESS: mem_req=1; mem_addr/we/be/wdata stable until ack. On mem_ack: capture
//   mem_rdata -> RESP. Counter reaches TIMEOUT_CYCLES without ack: drop mem_req,
//   RESP with timeout_err=1 and rdata=0. An ack in the same cycle as expiry wins.
//  RESP: owner's rvalid=1 for one cycle with rdata/flags -> IDLE. No new grant in RESP.
//  Latency: gnt in cycle 0, mem_req from cycle 1, ack in cycle k -> rvalid in k+1.
//   Fault path: gnt cycle 0, rvalid cycle 1. Back-to-back grants are 1 cycle apart minimum.
//  Lanes: o=addr[1:0]. IF is word-only (be=1111, we=0); fault if o!=0.
//   funct3[1:0]=00 byte: be=0001<<o, wdata={4{d[7:0]}}.
//   01 half: o in {0,2} else fault, be=0011<<o, wdata={2{d[15:0]}}.
//   10 word: o=0 else fault, be=1111.
//   funct3 011/110/111 -> fault. Stores with funct3[2]=1 -> fault.
//  Load extract: selected lane(s) right-justified. Sign-extend when funct3[2]=0,
//   zero-extend when funct3[2]=1. Store completion: ls_rdata=0.
// TESTING
//  LW 0x100, mem_rdata=0xDEADBEEF, ack after 3 cycles -> be=1111, ls_rdata=0xDEADBEEF at ack+1.
//  LB 0x103 / LBU 0x103, rdata=0x80FF0000 -> be=1000, rdata 0xFFFFFF80 / 0x00000080.
//  SH 0x102, wdata=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1.
//  LH 0x101 -> ls_gnt, ls_rvalid next cycle, rsp_fault=1, mem_req never high.
//  if_req & ls_req same cycle: LS_PRIORITY=1 -> LS then IF; =0 -> IF first, then alternate.
//  No ack for 255 cycles -> timeout_err & rvalid, rdata=0; reset_n low mid-ACCESS -> mem_req=0 at once.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// Single-port unified memory owner: arbitrates IF/LS requests, forms lanes and byte enables,
// waits for the memory ack with a timeout, and returns extended load data or fault flags.
module mem_access_arbiter #(
    parameter bit          LS_PRIORITY    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [31:0] ls_addr_i,
    input  logic [2:0]  ls_funct3_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,
    output logic        rsp_fault_o,
    output logic        timeout_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;        // 1 = LS owns the current transaction
    logic        last_ls_q, last_ls_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        fault_q, fault_d;
    logic        tmo_q, tmo_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        pick_ls;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wd;
    logic [2:0]  sel_f3;
    logic [1:0]  sel_off;
    logic        sel_fault;
    logic [3:0]  sel_be;
    logic [31:0] sel_wrep;
    logic [31:0] rd_shift;
    logic [31:0] rd_ext;
    logic        in_acc;
    logic        in_resp;

    // Winner selection and request decode; IF is treated as an LW with no store data.
    always_comb begin
        if (ls_req_i && if_req_i) begin
            pick_ls = LS_PRIORITY ? 1'b1 : !last_ls_q;
        end else begin
            pick_ls = ls_req_i;
        end
        sel_addr = pick_ls ? ls_addr_i : if_addr_i;
        sel_we   = pick_ls & ls_we_i;
        sel_f3   = pick_ls ? ls_funct3_i : 3'b010;
        sel_wd   = pick_ls ? ls_wdata_i : 32'h0;
        sel_off  = sel_addr[1:0];

        sel_fault = 1'b0;
        sel_be    = 4'b0000;
        sel_wrep  = 32'h0;
        case (sel_f3[1:0])
            2'b00: begin
                sel_be   = 4'b0001 << sel_off;
                sel_wrep = {4{sel_wd[7:0]}};
            end
            2'b01: begin
                sel_fault = sel_off[0];
                sel_be    = 4'b0011 << sel_off;
                sel_wrep  = {2{sel_wd[15:0]}};
            end
            2'b10: begin
                sel_fault = (sel_off != 2'b00);
                sel_be    = 4'b1111;
                sel_wrep  = sel_wd;
            end
            default: sel_fault = 1'b1;
        endcase
        if (sel_f3[2] && (sel_f3[1] || sel_we)) begin
            sel_fault = 1'b1;
        end
    end

    // Right-justify the addressed lane(s), then sign/zero extend.
    always_comb begin
        rd_shift = mem_rdata_i >> {addr_q[1:0], 3'b000};
        case (f3_q[1:0])
            2'b00:   rd_ext = f3_q[2] ? {24'h0, rd_shift[7:0]}
                                      : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   rd_ext = f3_q[2] ? {16'h0, rd_shift[15:0]}
                                      : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
        if (we_q) begin
            rd_ext = 32'h0;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_ls_d = last_ls_q;
        addr_d    = addr_q;
        we_d      = we_q;
        f3_d      = f3_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        fault_d   = fault_q;
        tmo_d     = tmo_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        if_gnt_o  = 1'b0;
        ls_gnt_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (if_req_i || ls_req_i) begin
                    if_gnt_o  = !pick_ls;
                    ls_gnt_o  = pick_ls;
                    owner_d   = pick_ls;
                    last_ls_d = pick_ls;
                    addr_d    = sel_addr;
                    we_d      = sel_we;
                    f3_d      = sel_f3;
                    wdata_d   = sel_wrep;
                    be_d      = sel_be;
                    fault_d   = sel_fault;
                    tmo_d     = 1'b0;
                    rdata_d   = 32'h0;
                    cnt_d     = 8'h0;
                    state_d   = sel_fault ? StResp : StAccess;
                end
            end
            StAccess: begin
                // An ack in the expiry cycle takes precedence over the timeout.
                if (mem_ack_i) begin
                    rdata_d = rd_ext;
                    state_d = StResp;
                end else if (cnt_q == TimeoutLast) begin
                    tmo_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            last_ls_q <= 1'b1;
            addr_q    <= 32'h0;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            wdata_q   <= 32'h0;
            be_q      <= 4'b0000;
            fault_q   <= 1'b0;
            tmo_q     <= 1'b0;
            rdata_q   <= 32'h0;
            cnt_q     <= 8'h0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_ls_q <= last_ls_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            f3_q      <= f3_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            fault_q   <= fault_d;
            tmo_q     <= tmo_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
        end
    end

    // Memory-side outputs decode straight from state so a reset drops them at once.
    always_comb begin
        in_acc        = (state_q == StAccess);
        in_resp       = (state_q == StResp);
        if_rvalid_o   = in_resp & !owner_q;
        ls_rvalid_o   = in_resp & owner_q;
        if_rdata_o    = if_rvalid_o ? rdata_q : 32'h0;
        ls_rdata_o    = ls_rvalid_o ? rdata_q : 32'h0;
        rsp_fault_o   = in_resp & fault_q;
        timeout_err_o = in_resp & tmo_q;
        mem_req_o     = in_acc;
        mem_we_o      = in_acc & we_q;
        mem_addr_o    = in_acc ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_be_o      = in_acc ? be_q : 4'b0000;
        mem_wdata_o   = in_acc ? wdata_q : 32'h0;
        busy_o        = (state_q != StIdle);
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench: dut_a uses LS priority and the default timeout, dut_b uses round-robin
// with a 3-cycle timeout to exercise alternation and the timeout boundary cheaply.
module tb_mem_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ls_req, ls_we, mem_ack;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [2:0]  ls_f3;
    logic        b_if_req, b_ls_req, b_mem_ack;

    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, rsp_fault, timeout_err;
    logic        mem_req, mem_we, busy;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_rsp_fault, b_timeout_err;
    logic        b_mem_req, b_mem_we, b_busy;
    logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_be;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_arbiter #(.LS_PRIORITY(1'b1), .TIMEOUT_CYCLES(255)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_funct3_i(ls_f3),
        .ls_wdata_i(ls_wdata), .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid),
        .ls_rdata_o(ls_rdata), .rsp_fault_o(rsp_fault), .timeout_err_o(timeout_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .busy_o(busy)
    );

    mem_access_arbiter #(.LS_PRIORITY(1'b0), .TIMEOUT_CYCLES(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(b_if_req), .if_addr_i(if_addr), .if_gnt_o(b_if_gnt),
        .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
        .ls_req_i(b_ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_funct3_i(ls_f3),
        .ls_wdata_i(ls_wdata), .ls_gnt_o(b_ls_gnt), .ls_rvalid_o(b_ls_rvalid),
        .ls_rdata_o(b_ls_rdata), .rsp_fault_o(b_rsp_fault), .timeout_err_o(b_timeout_err),
        .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_be_o(b_mem_be), .mem_wdata_o(b_mem_wdata), .mem_rdata_i(mem_rdata),
        .mem_ack_i(b_mem_ack), .busy_o(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Legal LS access on dut_a; ack is raised after waitc extra ACCESS cycles.
    task automatic ls_ok(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, input int waitc, input logic [31:0] rd,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd, input string tag);
        @(negedge clk);
        ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_f3 = f3; ls_wdata = wd;
        #1 chk({tag, ".gnt"}, ls_gnt, 1);
        @(negedge clk);
        ls_req = 1'b0;
        chk({tag, ".mem_req"}, mem_req, 1);
        chk({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({tag, ".mem_be"}, mem_be, exp_be);
        chk({tag, ".mem_we"}, mem_we, we);
        if (we) chk({tag, ".mem_wdata"}, mem_wdata, exp_wd);
        repeat (waitc) @(negedge clk);
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0;
        chk({tag, ".rvalid"}, ls_rvalid, 1);
        chk({tag, ".rdata"}, ls_rdata, exp_rd);
        chk({tag, ".fault"}, rsp_fault, 0);
    endtask

    task automatic ls_bad(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                          input string tag);
        @(negedge clk);
        ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_f3 = f3; ls_wdata = 32'hFFFF_FFFF;
        #1 chk({tag, ".gnt"}, ls_gnt, 1);
        @(negedge clk);
        ls_req = 1'b0;
        chk({tag, ".rvalid"}, ls_rvalid, 1);
        chk({tag, ".fault"}, rsp_fault, 1);
        chk({tag, ".mem_req"}, mem_req, 0);
        chk({tag, ".rdata"}, ls_rdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; if_req = 0; ls_req = 0; ls_we = 0; mem_ack = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0; mem_rdata = 0; ls_f3 = 0;
        b_if_req = 0; b_ls_req = 0; b_mem_ack = 0;
        repeat (2) @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.mem_req", mem_req, 0);
        chk("rst.mem_be", mem_be, 0);
        chk("rst.ls_rvalid", ls_rvalid, 0);
        chk("rst.b_busy", b_busy, 0);
        rst_n = 1'b1;

        ls_ok(0, 32'h100, 3'b010, 0, 2, 32'hDEAD_BEEF, 4'b1111, 0, 32'hDEAD_BEEF, "lw");
        ls_ok(0, 32'h103, 3'b000, 0, 0, 32'h80FF_0000, 4'b1000, 0, 32'hFFFF_FF80, "lb");
        ls_ok(0, 32'h103, 3'b100, 0, 1, 32'h80FF_0000, 4'b1000, 0, 32'h0000_0080, "lbu");
        ls_ok(0, 32'h101, 3'b000, 0, 0, 32'h0000_7F00, 4'b0010, 0, 32'h0000_007F, "lb+");
        ls_ok(0, 32'h102, 3'b001, 0, 0, 32'h80FF_0000, 4'b1100, 0, 32'hFFFF_80FF, "lh");
        ls_ok(0, 32'h100, 3'b101, 0, 0, 32'h1234_F00D, 4'b0011, 0, 32'h0000_F00D, "lhu");
        ls_ok(1, 32'h102, 3'b001, 32'h1234_ABCD, 0, 32'hFFFF_FFFF, 4'b1100, 32'hABCD_ABCD,
              0, "sh");
        ls_ok(1, 32'h101, 3'b000, 32'h0000_00A5, 0, 32'h0, 4'b0010, 32'hA5A5_A5A5, 0, "sb");
        ls_ok(1, 32'h104, 3'b010, 32'hCAFE_F00D, 1, 32'h0, 4'b1111, 32'hCAFE_F00D, 0, "sw");

        ls_bad(0, 32'h101, 3'b001, "lh_mis");
        ls_bad(0, 32'h102, 3'b010, "lw_mis");
        ls_bad(0, 32'h100, 3'b011, "f3_011");
        ls_bad(0, 32'h100, 3'b110, "f3_110");
        ls_bad(1, 32'h100, 3'b100, "sbu");

        // IF fetch and misaligned fetch
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h200;
        #1 chk("if.gnt", if_gnt, 1);
        @(negedge clk);
        if_req = 1'b0;
        chk("if.mem_be", mem_be, 4'b1111);
        chk("if.mem_we", mem_we, 0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("if.rvalid", if_rvalid, 1);
        chk("if.rdata", if_rdata, 32'h0000_0013);
        chk("if.ls_rvalid", ls_rvalid, 0);
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h202;
        #1 chk("if_mis.gnt", if_gnt, 1);
        @(negedge clk);
        if_req = 1'b0;
        chk("if_mis.rvalid", if_rvalid, 1);
        chk("if_mis.fault", rsp_fault, 1);
        chk("if_mis.mem_req", mem_req, 0);

        // LS priority: simultaneous requests, LS first, IF waits out RESP
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h400;
        ls_req = 1'b1; ls_we = 0; ls_addr = 32'h300; ls_f3 = 3'b010;
        #1 chk("pri.ls_gnt", ls_gnt, 1);
        chk("pri.if_gnt", if_gnt, 0);
        @(negedge clk);
        ls_req = 1'b0;
        chk("pri.mem_addr0", mem_addr, 32'h300);
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("pri.ls_rvalid", ls_rvalid, 1);
        chk("pri.resp_if_gnt", if_gnt, 0);
        @(negedge clk);
        #1 chk("pri.if_gnt2", if_gnt, 1);
        @(negedge clk);
        if_req = 1'b0;
        chk("pri.mem_addr1", mem_addr, 32'h400);
        mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("pri.if_rdata", if_rdata, 32'h2222_2222);

        // Round-robin on dut_b: IF, LS (timeout), IF (ack on expiry cycle), LS
        @(negedge clk);
        b_if_req = 1'b1; if_addr = 32'h10;
        b_ls_req = 1'b1; ls_we = 0; ls_addr = 32'h20; ls_f3 = 3'b010;
        #1 chk("rr.if_gnt", b_if_gnt, 1);
        chk("rr.ls_gnt", b_ls_gnt, 0);
        @(negedge clk);
        b_if_req = 1'b0;
        chk("rr.mem_addr0", b_mem_addr, 32'h10);
        b_mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        b_mem_ack = 1'b0;
        chk("rr.if_rvalid", b_if_rvalid, 1);
        chk("rr.if_rdata", b_if_rdata, 32'h0BAD_F00D);
        chk("rr.resp_ls_gnt", b_ls_gnt, 0);
        b_if_req = 1'b1; if_addr = 32'h14;
        @(negedge clk);
        #1 chk("rr.ls_gnt2", b_ls_gnt, 1);
        chk("rr.if_gnt2", b_if_gnt, 0);
        @(negedge clk);
        b_ls_req = 1'b0;
        chk("rr.mem_addr1", b_mem_addr, 32'h20);
        repeat (2) @(negedge clk);
        chk("tmo_b.last_req", b_mem_req, 1);
        @(negedge clk);
        chk("tmo_b.rvalid", b_ls_rvalid, 1);
        chk("tmo_b.err", b_timeout_err, 1);
        chk("tmo_b.rdata", b_ls_rdata, 0);
        chk("tmo_b.mem_req", b_mem_req, 0);
        b_ls_req = 1'b1; ls_addr = 32'h24;
        @(negedge clk);
        #1 chk("rr.if_gnt3", b_if_gnt, 1);
        chk("rr.ls_gnt3", b_ls_gnt, 0);
        @(negedge clk);
        b_if_req = 1'b0;
        chk("rr.mem_addr2", b_mem_addr, 32'h14);
        repeat (2) @(negedge clk);
        b_mem_ack = 1'b1; mem_rdata = 32'h1357_2468;
        @(negedge clk);
        b_mem_ack = 1'b0;
        chk("tie.rvalid", b_if_rvalid, 1);
        chk("tie.err", b_timeout_err, 0);
        chk("tie.rdata", b_if_rdata, 32'h1357_2468);
        @(negedge clk);
        #1 chk("rr.ls_gnt4", b_ls_gnt, 1);
        @(negedge clk);
        b_ls_req = 1'b0;
        b_mem_ack = 1'b1;
        @(negedge clk);
        b_mem_ack = 1'b0;
        chk("rr.ls_rdata4", b_ls_rdata, 32'h1357_2468);

        // Full 255-cycle timeout on dut_a
        @(negedge clk);
        ls_req = 1'b1; ls_we = 0; ls_addr = 32'h600; ls_f3 = 3'b010;
        #1 chk("tmo.gnt", ls_gnt, 1);
        @(negedge clk);
        ls_req = 1'b0;
        repeat (254) @(negedge clk);
        chk("tmo.last_req", mem_req, 1);
        @(negedge clk);
        chk("tmo.rvalid", ls_rvalid, 1);
        chk("tmo.err", timeout_err, 1);
        chk("tmo.rdata", ls_rdata, 0);

        // Reset in the middle of ACCESS abandons the access immediately
        @(negedge clk);
        ls_req = 1'b1; ls_addr = 32'h500;
        @(negedge clk);
        ls_req = 1'b0;
        chk("rst_mid.req_before", mem_req, 1);
        rst_n = 1'b0;
        #1 chk("rst_mid.mem_req", mem_req, 0);
        chk("rst_mid.busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid.idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
